regfile_writeback: RTL and testbench

- Write-side driver for the 8x16 CPU register file.
- Accepts results from two producers, the ALU and the memory-load path, over valid/ready handshakes, and queues them in an in-order buffer.
- Drains one entry per cycle onto the register file write port (write_en/wreg/writedata).
- Optionally forwards still-pending write data to the two register-file read addresses so that operand fetch never sees stale values.

---
 rtl/regfile_writeback.sv | 122 ++++++++++++
 tb/tb_regfile_writeback.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file write driver: in-order queue of ALU/load results, one write per cycle (commit 1 edge after accept); ready drops on full, ALU yields to load.
// Optional youngest-pending read forwarding is built only when WB_FWD_EN is defined.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [AW-1:0]              alu_rd,
  input  logic [DW-1:0]              alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [AW-1:0]              mem_rd,
  input  logic [DW-1:0]              mem_data,
  output logic                       write_en,
  output logic [AW-1:0]              wreg,
  output logic [DW-1:0]              writedata,
  input  logic [AW-1:0]              rega,
  input  logic [AW-1:0]              regb,
  output logic                       fwd1_hit,
  output logic [DW-1:0]              fwd1_data,
  output logic                       fwd2_hit,
  output logic [DW-1:0]              fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t     ent_q [DEPTH];
  wb_entry_t     ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_mem, push_alu, pop;
  logic [PW-1:0] alu_slot;
  logic [CW:0]   occ_alu;

  // A pending load consumes a slot before the ALU is considered, so loads win when space is short.
  assign occ_alu   = {1'b0, count_q} + (CW+1)'(mem_valid);
  assign mem_ready = rst_n && (count_q < CW'(DEPTH));
  assign alu_ready = rst_n && (occ_alu < (CW+1)'(DEPTH));

  assign push_mem  = mem_valid && mem_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign pop       = (count_q != '0);
  assign alu_slot  = tail_q + PW'(push_mem);

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_mem) + PW'(push_alu);
    count_d = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    if (push_mem) ent_d[tail_q]   = '{rd: mem_rd, data: mem_data};
    if (push_alu) ent_d[alu_slot] = '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign write_en  = !empty;
  assign wreg      = write_en ? ent_q[head_q].rd   : '0;
  assign writedata = write_en ? ent_q[head_q].data : '0;

`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (ent_q[fwd_idx].rd == rega) begin
          fwd1_hit  = 1'b1;
          fwd1_data = ent_q[fwd_idx].data;
        end
        if (ent_q[fwd_idx].rd == regb) begin
          fwd2_hit  = 1'b1;
          fwd2_data = ent_q[fwd_idx].data;
        end
      end
    end
  end
`else
  logic unused_fwd_addr;

  assign unused_fwd_addr = ^{rega, regb};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, single/dual push, sustained traffic, forwarding, mid-burst reset.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd = '0, mem_rd = '0, rega = '0, regb = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0;
  logic          write_en, fwd1_hit, fwd2_hit, empty;
  logic [AW-1:0] wreg;
  logic [DW-1:0] writedata, fwd1_data, fwd2_data;
  logic [CW-1:0] count;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0]    rf [8];
  logic [AW+DW-1:0] wlog [$];

  regfile_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .rega(rega), .regb(regb),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Register file model: captures the head entry at every edge where write_en is high.
  always @(posedge clk) begin
    if (write_en) begin
      rf[wreg] = writedata;
      wlog.push_back({wreg, writedata});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", write_en); end
    n_vec++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got alu=%b mem=%b want 0/0", alu_ready, mem_ready); end
    n_vec++; if (empty !== 1'b1 || count !== '0) begin n_err++; $display("FAIL rst_empty: got empty=%b count=%0d want 1/0", empty, count); end
    n_vec++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 || fwd1_data !== '0 || fwd2_data !== '0) begin
      n_err++; $display("FAIL rst_fwd: got %b/%h %b/%h want 0/0000 0/0000", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data); end
    n_vec++; if (wreg !== '0 || writedata !== '0) begin n_err++; $display("FAIL rst_wport: got %0d/%h want 0/0000", wreg, writedata); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    wlog.delete();
    alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h0005;
    #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_rdy: got %b want 1", alu_ready); end
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    n_vec++; if (write_en !== 1'b1 || wreg !== 3'd1 || writedata !== 16'h0005) begin
      n_err++; $display("FAIL single_wport: got we=%b wreg=%0d data=%h want 1/1/0005", write_en, wreg, writedata); end
    n_vec++; if (count !== CW'(1)) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
    @(negedge clk);
    n_vec++; if (empty !== 1'b1 || write_en !== 1'b0) begin n_err++; $display("FAIL single_drain: got empty=%b we=%b want 1/0", empty, write_en); end
    n_vec++; if (rf[1] !== 16'h0005 || wlog.size() != 1) begin n_err++; $display("FAIL single_rf: got r1=%h writes=%0d want 0005/1", rf[1], wlog.size()); end
  endtask

  task automatic test_dual_same_rd();
    wlog.delete();
    mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'h00AA;
    alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 16'h0BBB;
    #1;
    n_vec++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin n_err++; $display("FAIL dual_rdy: got mem=%b alu=%b want 1/1", mem_ready, alu_ready); end
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    n_vec++; if (count !== CW'(2) || wreg !== 3'd2 || writedata !== 16'h00AA) begin
      n_err++; $display("FAIL dual_first: got count=%0d wreg=%0d data=%h want 2/2/00AA", count, wreg, writedata); end
    @(negedge clk);
    n_vec++; if (count !== CW'(1) || writedata !== 16'h0BBB) begin n_err++; $display("FAIL dual_second: got count=%0d data=%h want 1/0BBB", count, writedata); end
    @(negedge clk);
    n_vec++; if (empty !== 1'b1 || rf[2] !== 16'h0BBB) begin n_err++; $display("FAIL dual_final: got empty=%b r2=%h want 1/0BBB", empty, rf[2]); end
    n_vec++; if (wlog.size() != 2 || wlog[0] !== {3'd2, 16'h00AA} || wlog[1] !== {3'd2, 16'h0BBB}) begin
      n_err++; $display("FAIL dual_order: got %0d writes want 2 in order 00AA,0BBB", wlog.size()); end
  endtask

  task automatic test_back_to_back();
    logic [AW+DW-1:0] expq [$];
    int  mcount = 0;
    bit  exp_mr, exp_ar;
    wlog.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      mem_valid = 1'b1; mem_rd = AW'(cyc % 8);       mem_data = DW'(16'h1000 + cyc);
      alu_valid = 1'b1; alu_rd = AW'((cyc + 3) % 8); alu_data = DW'(16'h2000 + cyc);
      #1;
      exp_mr = (mcount < DEPTH);
      exp_ar = (mcount + 1 < DEPTH);
      n_vec++; if (count !== CW'(mcount)) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", cyc, count, mcount); end
      n_vec++; if (mem_ready !== exp_mr || alu_ready !== exp_ar) begin
        n_err++; $display("FAIL b2b_rdy[%0d]: got mem=%b alu=%b want %b/%b", cyc, mem_ready, alu_ready, exp_mr, exp_ar); end
      if (exp_mr) expq.push_back({mem_rd, mem_data});
      if (exp_ar) expq.push_back({alu_rd, alu_data});
      mcount = mcount + int'(exp_mr) + int'(exp_ar) - ((mcount > 0) ? 1 : 0);
      @(negedge clk);
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int w = 0; w < 10 && !empty; w++) @(negedge clk);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_drain: got empty=%b want 1 within 10 cycles", empty); end
    n_vec++; if (wlog.size() != expq.size()) begin n_err++; $display("FAIL b2b_nwrites: got %0d want %0d", wlog.size(), expq.size()); end
    for (int k = 0; k < expq.size() && k < wlog.size(); k++) begin
      n_vec++; if (wlog[k] !== expq[k]) begin n_err++; $display("FAIL b2b_write[%0d]: got %h want %h", k, wlog[k], expq[k]); end
    end
  endtask

  task automatic test_forwarding();
    wlog.delete();
    rega = 3'd3; regb = 3'd4;
    mem_valid = 1'b1; mem_rd = 3'd3; mem_data = 16'h1111;
    alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h2222;
    #1;
    n_vec++; if (fwd1_hit !== 1'b0) begin n_err++; $display("FAIL fwd_same_cycle: got %b want 0", fwd1_hit); end
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    n_vec++; if (fwd1_hit !== FWD || fwd1_data !== (FWD ? 16'h2222 : 16'h0000)) begin
      n_err++; $display("FAIL fwd1_two: got %b/%h want %b/%h", fwd1_hit, fwd1_data, FWD, FWD ? 16'h2222 : 16'h0000); end
    n_vec++; if (fwd2_hit !== 1'b0 || fwd2_data !== '0) begin n_err++; $display("FAIL fwd2_miss: got %b/%h want 0/0000", fwd2_hit, fwd2_data); end
    @(negedge clk);
    n_vec++; if (fwd1_hit !== FWD || fwd1_data !== (FWD ? 16'h2222 : 16'h0000)) begin
      n_err++; $display("FAIL fwd1_one: got %b/%h want %b/%h", fwd1_hit, fwd1_data, FWD, FWD ? 16'h2222 : 16'h0000); end
    @(negedge clk);
    n_vec++; if (fwd1_hit !== 1'b0 || fwd1_data !== '0) begin n_err++; $display("FAIL fwd1_after: got %b/%h want 0/0000", fwd1_hit, fwd1_data); end
    n_vec++; if (rf[3] !== 16'h2222 || wlog.size() != 2 || wlog[0] !== {3'd3, 16'h1111}) begin
      n_err++; $display("FAIL fwd_writes: got r3=%h writes=%0d want 2222/2 (1111 first)", rf[3], wlog.size()); end
    rega = 3'd0; regb = 3'd0;
  endtask

  task automatic test_reset_mid();
    int wsize;
    mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 16'h5A5A;
    alu_valid = 1'b1; alu_rd = 3'd6; alu_data = 16'h6B6B;
    @(negedge clk);
    mem_rd = 3'd7; mem_data = 16'h7777;
    alu_rd = 3'd0; alu_data = 16'h0F0F;
    @(negedge clk);
    #1;
    n_vec++; if (count !== CW'(3)) begin n_err++; $display("FAIL rmid_count: got %0d want 3", count); end
    wsize = wlog.size();
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (write_en !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_err++; $display("FAIL rmid_async: got we=%b alu=%b mem=%b want 0/0/0", write_en, alu_ready, mem_ready); end
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    n_vec++; if (count !== '0 || write_en !== 1'b0 || wlog.size() != wsize) begin
      n_err++; $display("FAIL rmid_after: got count=%0d we=%b writes=%0d want 0/0/%0d", count, write_en, wlog.size(), wsize); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual_same_rd();
    test_back_to_back();
    test_forwarding();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
